// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the operand loader
package loader_pkg;

  localparam int OP_COUNT = 8;

  // Slot order on the operand bus: a1, b1, c1, d1, a2, b2, c2, d2
  localparam logic [2:0] SLOT_A1 = 3'd0;
  localparam logic [2:0] SLOT_B1 = 3'd1;
  localparam logic [2:0] SLOT_C1 = 3'd2;
  localparam logic [2:0] SLOT_D1 = 3'd3;
  localparam logic [2:0] SLOT_A2 = 3'd4;
  localparam logic [2:0] SLOT_B2 = 3'd5;
  localparam logic [2:0] SLOT_C2 = 3'd6;
  localparam logic [2:0] SLOT_D2 = 3'd7;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    RESULT = 2'd2
  } loader_state_e;

endpackage

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - serial operand loader feeding the 8-operand summing stage
module operand_loader
  import loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] a1,
  output logic [DATA_W-1:0] b1,
  output logic [DATA_W-1:0] c1,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] a2,
  output logic [DATA_W-1:0] b2,
  output logic [DATA_W-1:0] c2,
  output logic [DATA_W-1:0] d2,
  output logic              ops_valid,
  input  logic [DATA_W-1:0] sum_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [CNT_W-1:0]  frame_cnt
);

  loader_state_e     r_state;
  logic [2:0]        r_idx;
  logic [DATA_W-1:0] r_ops [OP_COUNT];
  logic [DATA_W-1:0] r_res_data;
  logic [CNT_W-1:0]  r_frame_cnt;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_res_take;
  logic [OP_COUNT-1:0] w_wr_en;

  // Handshake outputs depend on state only; rst masks in_ready during reset.
  assign w_in_ready = (r_state == LOAD) && !rst;
  assign w_accept   = in_valid && w_in_ready;
  assign w_res_take = (r_state == RESULT) && res_ready;

  assign in_ready  = w_in_ready;
  assign ops_valid = (r_state == SETTLE) || (r_state == RESULT);
  assign res_valid = (r_state == RESULT);
  assign res_data  = r_res_data;
  assign frame_cnt = r_frame_cnt;

  for (genvar g = 0; g < OP_COUNT; g++) begin : g_slot
    assign w_wr_en[g] = w_accept && (r_idx == 3'(g));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_ops[g] <= '0;
      end else if (w_wr_en[g]) begin
        r_ops[g] <= in_data;
      end
    end
  end

  assign a1 = r_ops[SLOT_A1];
  assign b1 = r_ops[SLOT_B1];
  assign c1 = r_ops[SLOT_C1];
  assign d1 = r_ops[SLOT_D1];
  assign a2 = r_ops[SLOT_A2];
  assign b2 = r_ops[SLOT_B2];
  assign c2 = r_ops[SLOT_C2];
  assign d2 = r_ops[SLOT_D2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_idx       <= '0;
      r_res_data  <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            r_idx <= r_idx + 3'd1;
            if (r_idx == SLOT_D2) begin
              r_state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          r_res_data <= sum_in;
          r_state    <= RESULT;
        end
        RESULT: begin
          if (w_res_take) begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            r_state     <= LOAD;
          end
        end
        default: begin
          r_state <= LOAD;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule
